// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - two-requester round-robin arbiter feeding a one-entry output register
// Define MUX2_RR_ARBITER_FIXED_PRIO_EN to pin ties to requester 0 (fixed priority).
module mux2_rr_arbiter #(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in0_val,
  output logic               in0_rdy,
  input  logic [p_nbits-1:0] in0_msg,
  input  logic               in1_val,
  output logic               in1_rdy,
  input  logic [p_nbits-1:0] in1_msg,
  output logic               sel,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out_msg,
  output logic               out_src
);

  logic               out_val_q, out_val_d;
  logic [p_nbits-1:0] out_msg_q, out_msg_d;
  logic               out_src_q, out_src_d;
  logic               prio_q,    prio_d;

  logic load;
  logic gnt0;
  logic gnt1;

  // Grant and handshake depend only on valids, prio and out_val, never on message data.
  always_comb begin
    load    = ~out_val_q | out_rdy;
    gnt0    = in0_val & (~in1_val | ~prio_q);
    gnt1    = in1_val & (~in0_val |  prio_q);
    sel     = gnt1;
    in0_rdy = load & gnt0 & ~rst;
    in1_rdy = load & gnt1 & ~rst;
  end

  always_comb begin
    out_val_d = out_val_q;
    out_msg_d = out_msg_q;
    out_src_d = out_src_q;
    prio_d    = prio_q;
    if (load) begin
      if (gnt0 | gnt1) begin
        out_val_d = 1'b1;
        out_msg_d = gnt1 ? in1_msg : in0_msg;
        out_src_d = gnt1;
        prio_d    = ~gnt1;
      end else begin
        out_val_d = 1'b0;
      end
    end
`ifdef MUX2_RR_ARBITER_FIXED_PRIO_EN
    prio_d = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_val_q <= 1'b0;
      out_msg_q <= '0;
      out_src_q <= 1'b0;
      prio_q    <= 1'b0;
    end else begin
      out_val_q <= out_val_d;
      out_msg_q <= out_msg_d;
      out_src_q <= out_src_d;
      prio_q    <= prio_d;
    end
  end

  assign out_val = out_val_q;
  assign out_msg = out_msg_q;
  assign out_src = out_src_q;

endmodule
